// File: rtl/open_mem_wr_arbiter.sv
// Round-robin arbiter for the single write port of the open-lane memory, with a zero-clear sequencer.
// Latency: grant is combinational; the memory write strobe, lane and data are registered one cycle after the grant.
// Backpressure: requesters hold i_req until o_gnt[r] is high; no grants are issued while clearing or in an i_clr cycle.
module open_mem_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 2,
  parameter int DWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*AWIDTH-1:0]   i_lane,
  input  logic [NREQ*DWIDTH-1:0]   i_data,
  input  logic                     i_clr,
  output logic [NREQ-1:0]          o_gnt,
  output logic [$clog2(NREQ)-1:0]  o_gnt_id,
  output logic                     o_busy,
  output logic                     o_mem_wr,
  output logic [AWIDTH-1:0]        o_mem_wlane,
  output logic [DWIDTH-1:0]        o_mem_wdata
);

  localparam int IDW   = $clog2(NREQ);
  localparam int LANES = 1 << AWIDTH;

  typedef enum logic {CLEAR, ARB} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] cnt;
  logic [IDW-1:0]    last;
  logic [IDW-1:0]    pick, hi_id, lo_id;
  logic              hi_any, lo_any;
  logic [AWIDTH-1:0] lane_sel;
  logic [DWIDTH-1:0] data_sel;
  logic              cnt_last;

  assign cnt_last = (cnt == AWIDTH'(LANES - 1));

  // Round-robin pick: lowest requester above the pointer, else lowest requester overall (wrap).
  always_comb begin
    hi_id  = '0;
    lo_id  = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        lo_id  = IDW'(i);
        lo_any = 1'b1;
        if (i > int'(last)) begin
          hi_id  = IDW'(i);
          hi_any = 1'b1;
        end
      end
    end
    pick = hi_any ? hi_id : lo_id;
  end

  // Select the picked requester's lane and data for the write registers.
  always_comb begin
    lane_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(pick) == i) begin
        lane_sel = i_lane[i*AWIDTH +: AWIDTH];
        data_sel = i_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Next state and combinational grant/busy outputs; i_clr beats any request in ARB.
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_gnt     = '0;
    o_gnt_id  = '0;
    case (state)
      CLEAR: begin
        o_busy = 1'b1;
        if (cnt_last) state_nxt = ARB;
      end
      ARB: begin
        if (i_clr) begin
          state_nxt = CLEAR;
        end else if (lo_any) begin
          o_gnt    = NREQ'(1) << pick;
          o_gnt_id = pick;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // State register; reset enters the clear sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  // Write-port registers, clear counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      last        <= IDW'(NREQ - 1);
      o_mem_wr    <= 1'b0;
      o_mem_wlane <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        CLEAR: begin
          o_mem_wr    <= 1'b1;
          o_mem_wlane <= cnt;
          o_mem_wdata <= '0;
          cnt         <= cnt_last ? '0 : cnt + 1'b1;
        end
        ARB: begin
          if (i_clr) begin
            o_mem_wr <= 1'b0;
            cnt      <= '0;
          end else if (lo_any) begin
            o_mem_wr    <= 1'b1;
            o_mem_wlane <= lane_sel;
            o_mem_wdata <= data_sel;
            last        <= pick;
          end else begin
            o_mem_wr <= 1'b0;
          end
        end
        default: o_mem_wr <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_open_mem_wr_arbiter.sv
// Testbench for open_mem_wr_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Latency: expected memory writes are queued at grant time and compared one clock later by a monitor.
// Backpressure: requests are re-drawn every cycle, so ungranted requesters simply re-present or drop.
module tb_open_mem_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int LANES = 1 << AW;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     i_req;
  logic [NREQ*AW-1:0]  i_lane;
  logic [NREQ*DW-1:0]  i_data;
  logic                i_clr;
  logic [NREQ-1:0]     o_gnt;
  logic [1:0]          o_gnt_id;
  logic                o_busy;
  logic                o_mem_wr;
  logic [AW-1:0]       o_mem_wlane;
  logic [DW-1:0]       o_mem_wdata;

  open_mem_wr_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_lane     (i_lane),
    .i_data     (i_data),
    .i_clr      (i_clr),
    .o_gnt      (o_gnt),
    .o_gnt_id   (o_gnt_id),
    .o_busy     (o_busy),
    .o_mem_wr   (o_mem_wr),
    .o_mem_wlane(o_mem_wlane),
    .o_mem_wdata(o_mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] lane;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model: pending clear lanes, pointer as integer, last written lane/data.
  int            clr_q[$];
  int            m_last;
  logic [AW-1:0] m_lane;
  logic [DW-1:0] m_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [NREQ-1:0] obs_gnt;
  int              obs_id;
  bit              fair_on = 0;
  int              fair_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    clr_q.delete();
    for (int l = 0; l < LANES; l++) clr_q.push_back(l);
    m_last = NREQ - 1;
    m_lane = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  // Called at a negedge with inputs applied; checks combinational outputs, queues the expected write.
  task automatic step();
    logic [NREQ-1:0] e_gnt;
    int              e_id;
    logic            e_busy;
    wr_t             it;
    bit              found;
    int              r;
    #1;
    e_gnt = '0;
    e_id  = 0;
    it.wr = 1'b0;
    if (clr_q.size() > 0) begin
      e_busy = 1'b1;
      m_lane = AW'(clr_q.pop_front());
      m_data = '0;
      it.wr  = 1'b1;
    end else begin
      e_busy = 1'b0;
      if (i_clr) begin
        for (int l = 0; l < LANES; l++) clr_q.push_back(l);
      end else begin
        found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          r = (m_last + k) % NREQ;
          if (!found && i_req[r]) begin
            found    = 1;
            e_gnt[r] = 1'b1;
            e_id     = r;
            m_last   = r;
            m_lane   = i_lane[r*AW +: AW];
            m_data   = i_data[r*DW +: DW];
            it.wr    = 1'b1;
          end
        end
      end
    end
    it.lane = m_lane;
    it.data = m_data;
    check("gnt", 32'(o_gnt), 32'(e_gnt));
    check("gnt_id", 32'(o_gnt_id), 32'(e_id));
    check("busy", 32'(o_busy), 32'(e_busy));
    check("gnt_onehot0", 32'($onehot0(o_gnt)), 32'd1);
    obs_gnt = o_gnt;
    obs_id  = int'(o_gnt_id);
    if (fair_on) begin
      if (o_gnt[1]) begin
        check("fair_wait_le_nreq_minus1", 32'(fair_wait <= NREQ - 1), 32'd1);
        fair_wait = 0;
      end else if (|o_gnt) begin
        fair_wait++;
      end
    end
    exp_q.push_back(it);
    @(negedge clk);
  endtask

  // Called at a negedge: asynchronous reset, checked immediately, released at a later negedge.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    check("rst_mem_wr", 32'(o_mem_wr), 32'd0);
    check("rst_wlane", 32'(o_mem_wlane), 32'd0);
    check("rst_wdata", 32'(o_mem_wdata), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_gnt_id", 32'(o_gnt_id), 32'd0);
    model_reset();
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: after each rising edge compare the registered write port with the oldest expectation.
  initial begin
    wr_t it;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check("mem_wr", 32'(o_mem_wr), 32'(it.wr));
        check("mem_wlane", 32'(o_mem_wlane), 32'(it.lane));
        check("mem_wdata", 32'(o_mem_wdata), 32'(it.data));
      end
    end
  end

  initial begin
    rst    = 1'b0;
    i_req  = '0;
    i_lane = '0;
    i_data = '0;
    i_clr  = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1);

    // Clear after reset, then idle.
    repeat (LANES + 2) step();

    // All requesters: strict rotation 0,1,2,3,0,...
    i_req  = 4'b1111;
    i_lane = 8'b11_10_01_00;
    i_data = 32'hD3C2B1A0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_order", 32'(obs_id), 32'(k % NREQ));
    end

    // Single requester 2, lane 3, data A5.
    i_req  = 4'b0100;
    i_lane = 8'h30;
    i_data = 32'h00A50000;
    step();
    check("single_gnt", 32'(obs_gnt), 32'h4);
    i_req = '0;
    repeat (2) step();

    // Clear request beats simultaneous requests; pointer survives the clear.
    i_req = 4'b0011;
    i_clr = 1'b1;
    i_lane = 8'h1B;
    i_data = 32'h44332211;
    step();
    check("clr_blocks_gnt", 32'(obs_gnt), 32'h0);
    i_clr = 1'b0;
    repeat (LANES) step();
    step();
    check("first_after_clr", 32'(obs_id), 32'd0);
    repeat (3) step();

    // Reset in the second clear cycle restarts the clear from lane 0.
    i_req = '0;
    do_reset(2);
    step();
    do_reset(3);
    repeat (LANES + 2) step();

    // Fairness: requester 1 holds, requesters 0 and 3 toggle.
    fair_on   = 1;
    fair_wait = 0;
    for (int k = 0; k < 40; k++) begin
      i_req  = {~k[0], 1'b0, 1'b1, k[0]};
      i_lane = (NREQ*AW)'($urandom);
      i_data = $urandom;
      step();
    end
    fair_on = 0;

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 1500; k++) begin
      i_req  = NREQ'($urandom);
      i_lane = (NREQ*AW)'($urandom);
      i_data = $urandom;
      i_clr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
      else step();
    end

    i_req = '0;
    i_clr = 1'b0;
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/open_mem_wr_arbiter.md
Name: open_mem_wr_arbiter

Overview:
Shares the single write port of the open-lane memory between NREQ requesters, using round-robin arbitration and a valid/grant handshake.
After reset, and on request, it runs a clear sequencer that writes zero to every lane, one lane per cycle, before arbitration resumes.
It sits between the pipeline write sources (e.g. writeback, forwarding/scoreboard updaters) and the memory's write inputs, driving wr/wlane/wdata through registers.

Parameters:
NREQ, 4, number of requesters (>=2)
AWIDTH, 2, lane address width; number of lanes LANES = 2**AWIDTH
DWIDTH, 8, data width per lane

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
i_req  input  NREQ  per-requester write request; bit r = requester r
i_lane  input  NREQ*AWIDTH  requester r lane in bits [r*AWIDTH +: AWIDTH]
i_data  input  NREQ*DWIDTH  requester r data in bits [r*DWIDTH +: DWIDTH]
i_clr  input  1  pulse: start the clear sequence
o_gnt  output  NREQ  one-hot grant (combinational); the request is consumed in the cycle o_gnt[r] is high
o_gnt_id  output  $clog2(NREQ)  index of granted requester, valid when |o_gnt
o_busy  output  1  high while clearing
o_mem_wr  output  1  registered write strobe to memory
o_mem_wlane  output  AWIDTH  registered write lane
o_mem_wdata  output  DWIDTH  registered write data

Behaviour:
- Reset (rst==0, async):
  - state=CLEAR, clear counter cnt=0, round-robin pointer last=NREQ-1.
  - o_mem_wr=0, o_mem_wlane=0, o_mem_wdata=0.
  - o_busy=1, o_gnt=0, o_gnt_id=0.
- States: CLEAR, ARB.
- CLEAR:
  - o_gnt=0 and o_busy=1.
  - Each clock: o_mem_wr<=1, o_mem_wlane<=cnt, o_mem_wdata<=0, cnt<=cnt+1.
  - When cnt==LANES-1: go to ARB, cnt<=0.
  - Exactly LANES write cycles. The first write is registered on the first rising edge after reset deassertion.
  - i_req is ignored; requesters hold until granted. i_clr is ignored.
- ARB:
  - o_busy=0.
  - If i_clr=1: go to CLEAR (cnt=0). o_gnt=0 that cycle; i_clr has priority over requests. o_mem_wr<=0.
  - Else if any i_req:
    - Grant the first set bit searching last+1, last+2, … modulo NREQ.
    - o_gnt one-hot; o_gnt_id=index. last<=index.
    - Next edge: o_mem_wr<=1, o_mem_wlane/o_mem_wdata<=that requester's lane/data.
  - Else: o_mem_wr<=0; lane/data hold their previous value.
- Latency: one cycle from grant to o_mem_wr at the memory. The memory commits on the following edge.
- Throughput: one write per cycle, back-to-back grants allowed.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- o_gnt depends combinationally on i_req, state, i_clr and last. No combinational path from o_gnt to any input.
- Reset mid-clear or mid-arbitration: immediate return to reset values. Clear restarts at lane 0; pending grants are lost and requesters must re-present.
- i_lane/i_data of non-granted requesters are don't-care.
- Same-lane requests from different requesters are serialized in grant order; the last grant wins.

Test Plan:
- Reset release, no requests, NREQ=4, LANES=4 -> o_mem_wr=1 for 4 cycles with o_mem_wlane 0,1,2,3 and wdata 0; o_busy falls after the 4th edge; o_mem_wr=0 afterwards.
- After clear, i_req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each o_mem_wr/o_mem_wlane/o_mem_wdata matches the granted requester one cycle later.
- After clear, single req2 (lane 3, data 8'hA5) -> o_gnt=4'b0100, o_gnt_id=2; next cycle o_mem_wr=1, lane=3, data=8'hA5.
- i_clr pulsed in ARB together with i_req=4'b0011 -> o_gnt=0 that cycle, 4-cycle clear follows, then requester 0 is granted first (pointer unchanged from before clear).
- rst asserted in the 2nd clear cycle, released 3 cycles later -> outputs 0 during reset; clear restarts with lane 0, full 4 writes.
- Requester 1 holds req, requesters 0/3 toggle each cycle -> requester 1 is granted within 3 grants every time; o_gnt is always one-hot or zero.
